// File: rtl/decodificador_pkg.sv
// Shared constants for the BCD-to-7-segment decoder: segment bit positions
// and the active-high segment pattern for each decimal digit.
package decodificador_pkg;

  // Segment bit positions inside the 7-bit display word
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high (1 = lit) patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7C; // no top bar (a)
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67; // no bottom bar (d)
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/decodificador_bcd_lut.sv
// Combinational BCD digit lookup: active-high segment pattern plus a flag
// for codes outside 0-9 (those, and any X/Z input, land in the default arm).
module decodificador_bcd_lut
  import decodificador_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg,
  output logic       invalid
);

  // Digit-to-segment table; everything not listed blanks and flags invalid
  always_comb begin
    seg     = SEG_BLANK;
    invalid = 1'b0;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: begin
        seg     = SEG_BLANK;
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decodificador_bcd.sv
// Registered BCD-to-7-segment decoder for one display digit. One clock of
// latency, no combinational input-to-output path. COMMON_ANODE=1 drives
// active-low segments; reset always means "all segments dark".
module decodificador_bcd
  import decodificador_pkg::*;
#(
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  output logic [6:0] display,
  output logic       err
);

  // Dark pattern in the polarity the pins actually use
  localparam logic [6:0] DISPLAY_RST = COMMON_ANODE ? ~SEG_BLANK : SEG_BLANK;

  logic [6:0] lut_seg;
  logic       lut_invalid;
  logic [6:0] display_d, display_q;
  logic       err_d, err_q;

  decodificador_bcd_lut u_lut (
    .bcd     (bcd),
    .seg     (lut_seg),
    .invalid (lut_invalid)
  );

  // Apply the pin polarity before the register so the output is a clean flop
  always_comb begin
    display_d = COMMON_ANODE ? ~lut_seg : lut_seg;
    err_d     = lut_invalid;
  end

  // Output registers, loaded every clock, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_q <= DISPLAY_RST;
      err_q     <= 1'b0;
    end else begin
      display_q <= display_d;
      err_q     <= err_d;
    end
  end

  assign display = display_q;
  assign err     = err_q;

endmodule

// File: tb/tb_decodificador_bcd.sv
// Bench for decodificador_bcd: a common-cathode and a common-anode instance
// share the same inputs and are compared against a segment-letter model.
module tb_decodificador_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd;
  logic [6:0] display_cc, display_ca;
  logic       err_cc, err_ca;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decodificador_bcd #(.COMMON_ANODE(1'b0)) dut_cc (
    .clk(clk), .rst(rst), .bcd(bcd), .display(display_cc), .err(err_cc)
  );

  decodificador_bcd #(.COMMON_ANODE(1'b1)) dut_ca (
    .clk(clk), .rst(rst), .bcd(bcd), .display(display_ca), .err(err_ca)
  );

  // ---------------- reference model ----------------
  // Each digit is described by the segment letters that light up on a real
  // display; the bit pattern is built from those letters.
  string lit_segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "cdefg", "abc", "abcdefg", "abcfg"};

  function automatic logic [6:0] ref_seg(int d, bit common_anode);
    logic [6:0] s;
    string      letters;
    s = 7'h00;
    if (d <= 9) begin
      letters = lit_segs[d];
      for (int i = 0; i < letters.len(); i++)
        s[letters[i] - "a"] = 1'b1;
    end
    return common_anode ? ~s : s;
  endfunction

  // Expected {display_cc, err_cc, display_ca, err_ca} after loading digit d
  function automatic logic [15:0] ref_out(int d);
    bit e;
    e = (d > 9);
    return {ref_seg(d, 1'b0), e, ref_seg(d, 1'b1), e};
  endfunction

  localparam logic [15:0] RST_OUT = {7'h00, 1'b0, 7'h7F, 1'b0};

  logic [15:0] got;
  logic [15:0] exp_q [$];

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1;
    bcd = 4'd8;
    #1;
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== RST_OUT) begin
      errors++;
      $display("FAIL reset_immediate got=%h exp=%h", got, RST_OUT);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {display_cc, err_cc, display_ca, err_ca};
      checks++;
      if (got !== RST_OUT) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got=%h exp=%h", i, got, RST_OUT);
      end
    end
    rst = 1'b0;
  endtask

  // Push digits one per clock; each negedge compares the previous digit
  task automatic run_stream(input int digits [$], input string name);
    logic [15:0] exp_v;
    exp_q.delete();
    foreach (digits[k]) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got = {display_cc, err_cc, display_ca, err_ca};
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL %s idx=%0d got=%h exp=%h", name, k - 1, got, exp_v);
        end
      end
      bcd = 4'(digits[k]);
      exp_q.push_back(ref_out(digits[k]));
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s last got=%h exp=%h", name, got, exp_v);
    end
  endtask

  task automatic test_sweep();
    int d [$];
    for (int i = 0; i <= 9; i++) d.push_back(i);
    run_stream(d, "sweep");
  endtask

  task automatic test_invalid();
    int d [$];
    for (int i = 10; i <= 15; i++) d.push_back(i);
    d.push_back(3);
    run_stream(d, "invalid");
  endtask

  task automatic test_latency();
    @(negedge clk);
    bcd = 4'd1;
    @(posedge clk);
    #2;
    bcd = 4'd2;
    #1;
    checks++;
    if (display_cc !== 7'h06) begin
      errors++;
      $display("FAIL latency_hold got=%h exp=%h", display_cc, 7'h06);
    end
    @(negedge clk);
    checks++;
    if (display_cc !== 7'h06) begin
      errors++;
      $display("FAIL latency_hold_neg got=%h exp=%h", display_cc, 7'h06);
    end
    @(posedge clk);
    #1;
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== ref_out(2)) begin
      errors++;
      $display("FAIL latency_update got=%h exp=%h", got, ref_out(2));
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bcd = 4'd8;
    @(negedge clk);
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== ref_out(8)) begin
      errors++;
      $display("FAIL async_pre got=%h exp=%h", got, ref_out(8));
    end
    #2;
    rst = 1'b1;
    #1;
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== RST_OUT) begin
      errors++;
      $display("FAIL async_immediate got=%h exp=%h", got, RST_OUT);
    end
    bcd = 4'd5;
    @(negedge clk);
    rst = 1'b0;
    #1;
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== RST_OUT) begin
      errors++;
      $display("FAIL async_release_noedge got=%h exp=%h", got, RST_OUT);
    end
    @(negedge clk);
    got = {display_cc, err_cc, display_ca, err_ca};
    checks++;
    if (got !== ref_out(5)) begin
      errors++;
      $display("FAIL async_first_load got=%h exp=%h", got, ref_out(5));
    end
  endtask

  task automatic test_common_anode();
    int d [$];
    d.push_back(0);
    d.push_back(12);
    run_stream(d, "common_anode");
    checks++;
    if (display_ca !== 7'h7F || err_ca !== 1'b1) begin
      errors++;
      $display("FAIL ca_bcd12 got=%h/%b exp=7f/1", display_ca, err_ca);
    end
  endtask

  task automatic test_random();
    int d [$];
    for (int i = 0; i < 200; i++) d.push_back(int'($urandom_range(0, 15)));
    run_stream(d, "random");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_latency();
    test_async_reset();
    test_common_anode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
